// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency RAM port between fetch and data requesters; ARB_FAIR_EN enables alternating tie-break
module mem_port_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_ren,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  output logic        inst_stall,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        ram_cs,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_dout,
  input  logic [31:0] ram_din
);
  typedef enum logic [2:0] {IDLE, INST, DATA, RESP_I, RESP_D} state_t;
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);
  state_t state;
  logic [31:0] lat_addr, lat_wdata;
  logic [3:0] cnt;
  logic lat_we, busy, data_req, grant_d;
  assign data_req = mem_ren | mem_wen;
`ifdef ARB_FAIR_EN
  logic last_grant;
  // last_grant: 1 = data was served last, so a tie now goes to fetch
  assign grant_d = data_req & ~(inst_ren & last_grant);
`else
  assign grant_d = data_req;
`endif
  assign busy = (state == INST) | (state == DATA);
  assign ram_cs = busy;
  assign ram_we = (state == DATA) & lat_we;
  assign ram_addr = busy ? lat_addr : '0;
  assign ram_dout = busy ? lat_wdata : '0;
  assign inst_stall = inst_ren & (state != RESP_I);
  assign mem_stall = data_req & (state != RESP_D);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      lat_addr <= '0;
      lat_wdata <= '0;
      lat_we <= 1'b0;
      inst_data <= '0;
      mem_din <= '0;
`ifdef ARB_FAIR_EN
      last_grant <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:
          if (grant_d) begin
            state <= DATA;
            lat_addr <= mem_addr;
            lat_wdata <= mem_dout;
            lat_we <= mem_wen;
            cnt <= CNT_INIT;
`ifdef ARB_FAIR_EN
            last_grant <= 1'b1;
`endif
          end else if (inst_ren) begin
            state <= INST;
            lat_addr <= inst_addr;
            lat_we <= 1'b0;
            cnt <= CNT_INIT;
`ifdef ARB_FAIR_EN
            last_grant <= 1'b0;
`endif
          end
        INST, DATA: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) begin
            if (state == INST) inst_data <= ram_din;
            else if (!lat_we) mem_din <= ram_din;
            state <= (state == INST) ? RESP_I : RESP_D;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares a single fixed-latency unified memory port between the core's instruction-fetch interface (`inst_ren`/`inst_addr`/`inst_data`) and its data interface (`mem_ren`/`mem_wen`/`mem_addr`/`mem_dout`/`mem_din`). It sits between `mips_core` and the RAM. It serialises accesses through a small FSM with a latency counter, and drives per-requester stall lines that the controller uses to freeze the pipeline.

## Interface
- `MEM_LAT`, default 2: RAM access latency in cycles, legal range 1..15.
- `clk` in 1: main clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `inst_ren` in 1: instruction read request from the core.
- `inst_addr` in 32: fetch address.
- `inst_data` out 32: registered fetched instruction.
- `inst_stall` out 1: fetch not yet served; the core holds the IF stage.
- `mem_ren` in 1: data read request.
- `mem_wen` in 1: data write request.
- `mem_addr` in 32: data address.
- `mem_dout` in 32: store data from the core.
- `mem_din` out 32: registered load data to the core.
- `mem_stall` out 1: data access not yet served; the core holds the pipeline.
- `ram_cs` out 1: RAM chip select.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out 32: RAM address.
- `ram_dout` out 32: RAM write data.
- `ram_din` in 32: RAM read data, valid in the last cycle of an access.

## Operation
- States: IDLE, INST, DATA, RESP_I, RESP_D. Encoding is free.
- Latched registers: `lat_addr`, `lat_wdata`, `lat_we`, the counter `cnt` (4 bits), and `inst_data`/`mem_din`.
- IDLE, when a data request is pending (`mem_ren | mem_wen`):
  - latch `mem_addr`, `mem_dout` and `lat_we = mem_wen`;
  - load `cnt = MEM_LAT-1`;
  - go to DATA.
- IDLE, when only `inst_ren` is pending: latch `inst_addr`, set `lat_we = 0`, load `cnt = MEM_LAT-1`, go to INST.
- IDLE, when no request is pending: stay in IDLE.
- IDLE arbitration: data beats instruction when both are pending. `ARB_FAIR_EN` changes this rule (see Configuration).
- INST and DATA:
  - `ram_cs = 1`, `ram_addr = lat_addr`, `ram_dout = lat_wdata`;
  - `ram_we = lat_we`, and only in DATA;
  - `cnt` decrements each cycle.
  - When `cnt == 0`: capture `ram_din` into `inst_data` (from INST) or into `mem_din` (from DATA, reads only), then go to RESP_I or RESP_D.
- RESP_I and RESP_D: one cycle, `ram_cs = 0`, the served requester's stall goes low, then return to IDLE unconditionally.
- `inst_stall = inst_ren & (state != RESP_I)`.
- `mem_stall = (mem_ren | mem_wen) & (state != RESP_D)`.
- Stalls are combinational from the state and the request inputs.
- Outside INST and DATA: `ram_cs`, `ram_we`, `ram_addr` and `ram_dout` are all 0.
- `mem_ren & mem_wen` together is treated as a write; `mem_din` is unchanged.
- The core must hold its request inputs stable while the matching stall is high. Changes are ignored after latching.

## Timing
- Reset values:
  - state = IDLE, `cnt = 0`;
  - `lat_*`, `inst_data` and `mem_din` = 0;
  - `ram_cs = ram_we = 0`, `ram_addr = ram_dout = 0`;
  - the stall outputs follow their formulas, so a pending request reads as stalled.
- Fair-mode pointer `last_grant` resets to INST, so data wins the first tie.
- Per access, with the request seen in IDLE at cycle 0:
  - `ram_cs` high in cycles 1..MEM_LAT;
  - `ram_din` sampled at the end of cycle MEM_LAT;
  - RESP in cycle MEM_LAT+1, where the stall is low and the returned data is valid;
  - the core advances at the end of cycle MEM_LAT+1.
- Service time is MEM_LAT+2 cycles per access.
- Back-to-back requests: after RESP the FSM spends one cycle in IDLE before the next access. Throughput is one access per MEM_LAT+2 cycles.
- Both requests pending: data is served first (cycles 0..MEM_LAT+1). Instruction is served next (cycles MEM_LAT+2..2·MEM_LAT+3), with `inst_stall` high throughout the first access.
- `rst` asserted mid-access aborts it at that edge:
  - `ram_cs`/`ram_we` are low in the next cycle;
  - no capture takes place;
  - a partially performed write is the RAM's concern.
- `MEM_LAT = 1`: INST/DATA last exactly one cycle (`cnt` loads 0).

## Configuration
- Macro: `ARB_FAIR_EN`.
- Defined: the one-bit `last_grant` register records the requester served on each IDLE grant. When both are pending, the requester not in `last_grant` wins; a single pending request always wins.
- Undefined: fixed data-over-instruction priority, and `last_grant` is not instantiated.

## Test plan
- MEM_LAT=2, single fetch of `inst_addr = 0x40`, RAM returns `0x8C010004` → `ram_cs` high cycles 1-2; `inst_stall` low only in cycle 3; `inst_data = 0x8C010004` in cycle 3.
- Store with `mem_wen = 1`, `mem_addr = 0x100`, `mem_dout = 0xDEADBEEF` → `ram_we = ram_cs = 1` with that address and data for 2 cycles; `mem_din` unchanged; `mem_stall` low in cycle 3.
- Fetch and load pending together, fixed priority → load served in cycles 1-2 (RESP_D in cycle 3); fetch served in cycles 5-6 (RESP_I in cycle 7); `inst_stall` high in cycles 0-6.
- `ARB_FAIR_EN` defined, both requesters continuously pending → grants alternate D, I, D, I; no requester waits more than 2·(MEM_LAT+2) cycles.
- `rst` pulsed in cycle 1 of a DATA access → `ram_cs = 0` next cycle; state IDLE; `mem_din` = 0; a new request is served with full latency.
- MEM_LAT=1, 4 back-to-back fetches → RESP_I every 3 cycles; `ram_addr` sequence matches the requested addresses.
